// File: rtl/mac2fifod_if.sv
// Handshake/bus bundle between the MAC receive side, the receive RAM and the receive FIFO.
// The master modport is the copy engine; slave is the surrounding MAC/RAM/FIFO.
interface mac2fifod_if #(
   parameter int unsigned ADDR_W = 11
);
   logic              fs_udp_rx;
   logic [15:0]       udp_rx_len;
   logic [ADDR_W-1:0] udp_rx_addr;
   logic [7:0]        udp_rxd;
   logic              fd_udp_rx;
   logic              fifo_full;
   logic              fifo_txen;
   logic [7:0]        fifo_txd;
   logic              err;
   logic [3:0]        state_mac2fifod;

   modport master (
      input  fs_udp_rx, udp_rx_len, udp_rxd, fifo_full,
      output udp_rx_addr, fd_udp_rx, fifo_txen, fifo_txd, err, state_mac2fifod
   );

   modport slave (
      output fs_udp_rx, udp_rx_len, udp_rxd, fifo_full,
      input  udp_rx_addr, fd_udp_rx, fifo_txen, fifo_txd, err, state_mac2fifod
   );
endinterface

// File: rtl/mac2fifod.sv
// Copies a received UDP payload from the MAC receive RAM into the receive FIFO,
// with a 2-entry skid buffer so a full FIFO stalls the copy without losing bytes.
module mac2fifod #(
   parameter int unsigned ADDR_W  = 11,
   parameter int unsigned MAX_LEN = 2048
) (
   input logic         clk,
   input logic         rst,
   mac2fifod_if.master bus
);
   localparam int unsigned          CNT_W   = $clog2(MAX_LEN + 1);
   localparam logic [CNT_W-1:0]     ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0]     MAX_C   = CNT_W'(MAX_LEN);
   localparam logic [15:0]          MAX_16  = 16'(MAX_LEN);

   typedef enum logic [3:0] {
      IDLE = 4'd1,
      LOAD = 4'd2,
      COPY = 4'd3,
      DONE = 4'd4,
      WAIT = 4'd5
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] len;
   logic [CNT_W-1:0] rd_cnt;
   logic [CNT_W-1:0] wr_cnt;
   logic             rd_pend;
   logic [1:0]       buf_cnt;
   logic [7:0]       buf_q [2];
   logic             pop;
   logic             rd_go;
   logic [2:0]       occ;

   // Occupancy counts the byte still coming back from RAM, so the buffer never overflows.
   always_comb begin
      pop   = (buf_cnt != 2'd0) && !bus.fifo_full;
      occ   = 3'(buf_cnt) + 3'(rd_pend) - 3'(pop);
      rd_go = (state == COPY) && (rd_cnt < len) && (occ < 3'd2);
   end

   assign bus.fifo_txen       = pop;
   assign bus.fifo_txd        = buf_q[0];
   assign bus.state_mac2fifod = state;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state           <= IDLE;
         len             <= '0;
         rd_cnt          <= '0;
         wr_cnt          <= '0;
         rd_pend         <= 1'b0;
         buf_cnt         <= '0;
         buf_q[0]        <= '0;
         buf_q[1]        <= '0;
         bus.udp_rx_addr <= '0;
         bus.fd_udp_rx   <= 1'b0;
         bus.err         <= 1'b0;
      end else begin
         bus.fd_udp_rx <= 1'b0;
         rd_pend       <= rd_go;

         if (rd_go) begin
            bus.udp_rx_addr <= rd_cnt[ADDR_W-1:0];
            rd_cnt          <= rd_cnt + ONE;
         end

         if (pop) begin
            wr_cnt <= wr_cnt + ONE;
         end

         // Head is always buf_q[0]; a pop shifts entry 1 down, a capture fills the next free slot.
         case ({rd_pend, pop})
            2'b10: begin
               buf_q[buf_cnt[0]] <= bus.udp_rxd;
               buf_cnt           <= buf_cnt + 2'd1;
            end
            2'b01: begin
               buf_q[0] <= buf_q[1];
               buf_cnt  <= buf_cnt - 2'd1;
            end
            2'b11: begin
               if (buf_cnt == 2'd1) begin
                  buf_q[0] <= bus.udp_rxd;
               end else begin
                  buf_q[0] <= buf_q[1];
                  buf_q[1] <= bus.udp_rxd;
               end
            end
            default: ;
         endcase

         case (state)
            IDLE: begin
               if (bus.fs_udp_rx) state <= LOAD;
            end
            LOAD: begin
               len    <= (bus.udp_rx_len > MAX_16) ? MAX_C : bus.udp_rx_len[CNT_W-1:0];
               rd_cnt <= '0;
               wr_cnt <= '0;
               if (bus.udp_rx_len > MAX_16) bus.err <= 1'b1;
               if (bus.udp_rx_len == 16'd0) begin
                  state         <= DONE;
                  bus.fd_udp_rx <= 1'b1;
               end else begin
                  state <= COPY;
               end
            end
            COPY: begin
               if (pop && ((wr_cnt + ONE) == len)) begin
                  state         <= DONE;
                  bus.fd_udp_rx <= 1'b1;
               end
            end
            DONE: begin
               state <= WAIT;
            end
            WAIT: begin
               if (!bus.fs_udp_rx) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mac2fifod.sv
// Randomized bench for mac2fifod: a byte-queue model of the payload copy checks every
// FIFO write, the done strobe timing and the sticky error flag, plus literal expectations.
module tb_mac2fifod;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [7:0] ram [2048];

   mac2fifod_if #(.ADDR_W(11)) bus ();

   mac2fifod #(.ADDR_W(11), .MAX_LEN(2048)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.udp_rxd = ram[bus.udp_rx_addr];

   int unsigned checks   = 0;
   int unsigned failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   // Model state shared with the stimulus thread.
   logic [7:0]  exp_q [$];
   int          cyc = 0;
   int          fs_cyc = 0, first_wr_cyc = 0, last_wr_cyc = 0, fd_cyc = 0, err_due = 0;
   int unsigned copy_wr = 0, total_wr = 0, fd_cnt = 0, run = 0, max_run = 0, n_exp = 0;
   logic [7:0]  first_byte = '0, last_byte = '0;
   logic        armed = 1'b1, busy = 1'b0, exp_err = 1'b0, err_pending = 1'b0, prev_rst = 1'b1;

   // Compare process: samples mid-cycle, after the stimulus has settled.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         if (!rst) begin
            exp_q.delete();
            busy = 1'b0; armed = 1'b1; exp_err = 1'b0; err_pending = 1'b0; run = 0;
            prev_rst = 1'b0;
            continue;
         end
         if (!prev_rst) begin
            chk("rst_state", 32'(bus.state_mac2fifod), 32'd1);
            chk("rst_addr",  32'(bus.udp_rx_addr), 32'd0);
            chk("rst_fd",    32'(bus.fd_udp_rx), 32'd0);
            chk("rst_txen",  32'(bus.fifo_txen), 32'd0);
            chk("rst_txd",   32'(bus.fifo_txd), 32'd0);
            chk("rst_err",   32'(bus.err), 32'd0);
         end
         prev_rst = 1'b1;

         if (bus.fifo_txen) begin
            chk("txen_while_full", 32'(bus.fifo_full), 32'd0);
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               chk("data", 32'(bus.fifo_txd), 32'(exp_q[0]));
               void'(exp_q.pop_front());
            end
            copy_wr++; total_wr++;
            if (copy_wr == 1) begin
               first_wr_cyc = cyc;
               first_byte   = bus.fifo_txd;
            end
            last_wr_cyc = cyc;
            last_byte   = bus.fifo_txd;
            run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end

         if (bus.fd_udp_rx) begin
            fd_cnt++;
            fd_cyc = cyc;
            chk("fd_expected", 32'(busy), 32'd1);
            chk("fd_all_written", exp_q.size(), 32'd0);
            chk("fd_timing", 32'(cyc), (n_exp == 0) ? 32'(fs_cyc + 2) : 32'(last_wr_cyc + 1));
            busy = 1'b0;
         end

         if (err_pending && cyc >= err_due) begin
            exp_err     = 1'b1;
            err_pending = 1'b0;
         end
         chk("err", 32'(bus.err), 32'(exp_err));

         if (!bus.fs_udp_rx && !busy) armed = 1'b1;
         if (bus.fs_udp_rx && armed && !busy) begin
            busy    = 1'b1;
            armed   = 1'b0;
            fs_cyc  = cyc;
            copy_wr = 0;
            max_run = 0;
            n_exp   = (bus.udp_rx_len > 16'd2048) ? 2048 : int'(bus.udp_rx_len);
            if (bus.udp_rx_len > 16'd2048) begin
               err_pending = 1'b1;
               err_due     = cyc + 2;
            end
            for (int unsigned i = 0; i < n_exp; i++) exp_q.push_back(ram[i]);
         end
      end
   end

   // mode 0: FIFO never full; 1: random full and fs toggling; 2: full for 5 cycles after 3rd write.
   task automatic run_copy(input int unsigned len, input int unsigned mode, input int unsigned hold);
      int unsigned fd0 = fd_cnt;
      int unsigned forced = 0;
      int unsigned n = (len > 2048) ? 2048 : len;
      int unsigned tw0, fd1;
      bit got = 1'b0;
      @(negedge clk);
      bus.udp_rx_len = 16'(len);
      bus.fs_udp_rx  = 1'b1;
      for (int i = 0; i < 6000 && !got; i++) begin
         @(negedge clk);
         if (i >= 1) bus.udp_rx_len = 16'($urandom);
         case (mode)
            0: bus.fifo_full = 1'b0;
            1: begin
               bus.fifo_full = ($urandom_range(0, 3) == 0);
               bus.fs_udp_rx = (i >= 1 && copy_wr + 3 < n) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            default: begin
               if (copy_wr >= 3 && forced < 5) begin
                  bus.fifo_full = 1'b1;
                  forced++;
               end else begin
                  bus.fifo_full = 1'b0;
               end
            end
         endcase
         if (fd_cnt != fd0) got = 1'b1;
      end
      chk("fd_timeout", 32'(got), 32'd1);
      bus.fifo_full = 1'b0;
      bus.fs_udp_rx = 1'b1;
      tw0 = total_wr;
      fd1 = fd_cnt;
      repeat (hold) @(negedge clk);
      if (hold > 0) begin
         chk("hold_no_writes", total_wr - tw0, 32'd0);
         chk("hold_no_fd", fd_cnt - fd1, 32'd0);
      end
      bus.fs_udp_rx = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      bit got;
      int unsigned fd0;
      bus.fs_udp_rx  = 1'b0;
      bus.udp_rx_len = '0;
      bus.fifo_full  = 1'b0;
      for (int unsigned i = 0; i < 2048; i++) ram[i] = 8'(8'hA0 + i);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      run_copy(12, 0, 0);
      chk("t1_writes", copy_wr, 32'd12);
      chk("t1_first_latency", 32'(first_wr_cyc - fs_cyc), 32'd4);
      chk("t1_back_to_back", max_run, 32'd12);
      chk("t1_first_byte", 32'(first_byte), 32'hA0);
      chk("t1_last_byte", 32'(last_byte), 32'hAB);

      run_copy(12, 2, 0);
      chk("t2_writes", copy_wr, 32'd12);
      chk("t2_last_byte", 32'(last_byte), 32'hAB);

      run_copy(0, 0, 0);
      chk("t3_writes", copy_wr, 32'd0);
      chk("t3_fd_delay", 32'(fd_cyc - fs_cyc), 32'd2);

      run_copy(5, 0, 20);
      chk("t5_writes", copy_wr, 32'd5);
      run_copy(7, 0, 0);
      chk("t5_retrigger_writes", copy_wr, 32'd7);

      // Reset in the middle of a 12-byte copy.
      fd0 = fd_cnt;
      got = 1'b0;
      @(negedge clk);
      bus.udp_rx_len = 16'd12;
      bus.fs_udp_rx  = 1'b1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (copy_wr >= 5) got = 1'b1;
      end
      chk("t6_reach_5", 32'(got), 32'd1);
      rst = 1'b0;
      bus.fs_udp_rx = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      chk("t6_no_fd", fd_cnt - fd0, 32'd0);
      run_copy(12, 0, 0);
      chk("t6_full_copy", copy_wr, 32'd12);

      run_copy(3000, 0, 0);
      chk("t4_writes", copy_wr, 32'd2048);
      chk("t4_last_byte", 32'(last_byte), 32'h9F);
      chk("t4_err", 32'(bus.err), 32'd1);

      for (int unsigned i = 0; i < 2048; i++) ram[i] = 8'($urandom);
      for (int k = 0; k < 25; k++) begin
         int unsigned len = $urandom_range(1, 40);
         run_copy(len, 1, $urandom_range(0, 3));
         chk("rand_writes", copy_wr, len);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
